// File: rtl/ecc_log_pkg.sv
// Shared types for the ECC error logger: event classes, FIFO entry layout and
// the read-flag classifier. ECC_ERR_LOGGER_TIMESTAMP_EN adds a tstamp field to entries.
package ecc_log_pkg;

    localparam int ENTRY_ADDR_W = 16;
    localparam int TSTAMP_W     = 16;

    localparam int FLAG_DET  = 0;
    localparam int FLAG_CORR = 1;
    localparam int FLAG_UNC  = 2;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        CORR   = 2'b01,
        UNCORR = 2'b10
    } evt_type_e;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [1:0]              sel;
        evt_type_e               etype;
`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
        logic [TSTAMP_W-1:0]     tstamp;
`endif
    } evt_entry_t;

    // A detected error that was not corrected counts as uncorrectable.
    function automatic evt_type_e classify(input logic [0:2] flag);
        evt_type_e c;
        if (flag[FLAG_UNC]) begin
            c = UNCORR;
        end else if (flag[FLAG_CORR]) begin
            c = CORR;
        end else if (flag[FLAG_DET]) begin
            c = UNCORR;
        end else begin
            c = NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/ecc_evt_fifo.sv
// Single-clock event FIFO of evt_entry_t. A push into a full FIFO is accepted
// only when a pop happens on the same edge; otherwise it is refused.
module ecc_evt_fifo
    import ecc_log_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  evt_entry_t entry_i,
    input  logic       pop_i,
    output evt_entry_t head_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    evt_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o = (occ_q == {OCC_W{1'b0}});
    assign full_o  = (occ_q == OCC_W'(DEPTH));

    // Handshake qualification, pointer and occupancy next state.
    always_comb begin
        pop_ok_s  = pop_i & ~empty_o;
        push_ok_s = push_i & (~full_o | pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        occ_d = occ_q + OCC_W'(push_ok_s) - OCC_W'(pop_ok_s);
    end

    // Head is forced to zero when empty so stale entries never leak out.
    always_comb begin
        head_o = '0;
        if (!empty_o) begin
            head_o = mem_q[rd_ptr_q];
        end else begin
            head_o = '0;
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= entry_i;
            end
        end
    end

endmodule

// File: rtl/ecc_err_logger.sv
// ECC read-error logger: classifies read flags, keeps saturating counters,
// queues events for the MCU and raises irq. Macro ECC_ERR_LOGGER_TIMESTAMP_EN adds evt_tstamp.
module ecc_err_logger
    import ecc_log_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [0:2]        flag_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [1:0]        ecc_sel_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ADDR_W-1:0] evt_addr,
    output logic [1:0]        evt_sel,
    output logic [1:0]        evt_type,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic              overflow,
    input  logic              clr,
    input  logic              irq_en,
    output logic              irq
`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
    ,
    output logic [TSTAMP_W-1:0] evt_tstamp
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    evt_type_e        class_s;
    logic             event_s;
    logic             drop_s;
    logic             empty_s;
    logic             full_s;
    evt_entry_t       entry_s;
    evt_entry_t       head_s;
    logic [CNT_W-1:0] corr_q, corr_d;
    logic [CNT_W-1:0] uncorr_q, uncorr_d;
    logic             ovf_q, ovf_d;
    logic             irq_q, irq_d;
`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
    logic [TSTAMP_W-1:0] tstamp_q;
`endif

    ecc_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (event_s),
        .entry_i (entry_s),
        .pop_i   (evt_ready),
        .head_o  (head_s),
        .empty_o (empty_s),
        .full_o  (full_s)
    );

    // Classification, counter/overflow next state and irq request.
    always_comb begin
        class_s  = classify(flag_in);
        event_s  = rd_valid & (class_s != NONE);
        drop_s   = event_s & full_s & ~(evt_ready & ~empty_s);
        entry_s  = '0;
        entry_s.addr  = ENTRY_ADDR_W'(addr_in);
        entry_s.sel   = ecc_sel_in;
        entry_s.etype = class_s;
`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
        entry_s.tstamp = tstamp_q;
`endif
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        ovf_d    = ovf_q;
        if (clr) begin
            corr_d   = {CNT_W{1'b0}};
            uncorr_d = {CNT_W{1'b0}};
            ovf_d    = 1'b0;
        end else begin
            ovf_d = ovf_q | drop_s;
            if (event_s && (class_s == CORR) && (corr_q != CNT_MAX)) begin
                corr_d = corr_q + CNT_W'(1);
            end else begin
                corr_d = corr_q;
            end
            if (event_s && (class_s == UNCORR) && (uncorr_q != CNT_MAX)) begin
                uncorr_d = uncorr_q + CNT_W'(1);
            end else begin
                uncorr_d = uncorr_q;
            end
        end
        // Driven from the registered state, so irq trails the FIFO/overflow by a cycle.
        irq_d = irq_en & (~empty_s | ovf_q);
    end

    // Counter, overflow and interrupt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            corr_q   <= '0;
            uncorr_q <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
    // Free-running cycle counter sampled into each pushed entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + TSTAMP_W'(1);
        end
    end

    assign evt_tstamp = head_s.tstamp;
`endif

    assign evt_valid  = ~empty_s;
    assign evt_addr   = ADDR_W'(head_s.addr);
    assign evt_sel    = head_s.sel;
    assign evt_type   = head_s.etype;
    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;
    assign overflow   = ovf_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_ecc_err_logger.sv
// Scoreboard bench for ecc_err_logger: stimulus queues expected events, a
// negedge monitor checks each popped head; counters/flags checked directly.
module tb_ecc_err_logger;
    import ecc_log_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rd_valid, evt_ready, clr, irq_en;
    logic [0:2]  flag_in;
    logic [15:0] addr_in;
    logic [1:0]  ecc_sel_in;
    logic        evt_valid, overflow, irq;
    logic [15:0] evt_addr;
    logic [1:0]  evt_sel, evt_type;
    logic [7:0]  corr_cnt, uncorr_cnt;
`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
    logic [15:0] evt_tstamp;
    logic [15:0] t0, t1;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  sel;
        logic [1:0]  etype;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    ecc_err_logger #(.ADDR_W(16), .DEPTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_valid   (rd_valid),
        .flag_in    (flag_in),
        .addr_in    (addr_in),
        .ecc_sel_in (ecc_sel_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_addr   (evt_addr),
        .evt_sel    (evt_sel),
        .evt_type   (evt_type),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .overflow   (overflow),
        .clr        (clr),
        .irq_en     (irq_en),
        .irq        (irq)
`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
        ,
        .evt_tstamp (evt_tstamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [2:0] f, input logic [15:0] a, input logic [1:0] s,
                      input bit expect_push, input logic [1:0] t);
        exp_t e;
        rd_valid   = 1'b1;
        flag_in    = f;
        addr_in    = a;
        ecc_sel_in = s;
        if (expect_push) begin
            e.addr = a; e.sel = s; e.etype = t;
            exp_q.push_back(e);
        end
        tick();
        rd_valid = 1'b0;
        flag_in  = 3'b000;
    endtask

    // Scoreboard monitor: every accepted pop is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_addr", {16'd0, evt_addr}, {16'd0, e.addr});
                chk("pop_sel",  {30'd0, evt_sel},  {30'd0, e.sel});
                chk("pop_type", {30'd0, evt_type}, {30'd0, e.etype});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rd_valid = 1'b0; evt_ready = 1'b0; clr = 1'b0; irq_en = 1'b0;
        flag_in = 3'b000; addr_in = 16'h0000; ecc_sel_in = 2'b00;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_corr", corr_cnt, 8'd0);
        chk("rst_uncorr", uncorr_cnt, 8'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_addr", evt_addr, 16'h0000);

        // Clean read: no effect.
        tick();
        ev(3'b000, 16'h0010, 2'b00, 1'b0, 2'b00);
        tick();
        @(negedge clk);
        chk("clean_valid", evt_valid, 1'b0);
        chk("clean_corr", corr_cnt, 8'd0);
        chk("clean_uncorr", uncorr_cnt, 8'd0);
        chk("clean_irq", irq, 1'b0);

        // Single corrected event, irq one cycle behind, then pop.
        irq_en = 1'b1;
        ev(3'b010, 16'h1234, 2'b01, 1'b1, CORR);
        @(negedge clk);
        chk("corr_valid", evt_valid, 1'b1);
        chk("corr_cnt1", corr_cnt, 8'd1);
        chk("corr_irq_lag", irq, 1'b0);
        tick();
        @(negedge clk);
        chk("corr_irq", irq, 1'b1);
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("popped_valid", evt_valid, 1'b0);
        chk("popped_irq_lag", irq, 1'b1);
        tick();
        @(negedge clk);
        chk("popped_irq", irq, 1'b0);

        // Nine uncorrectable events into an 8-deep FIFO.
        tick();
        for (int i = 0; i < 9; i++) begin
            ev(3'b001, 16'(i), 2'b10, (i < 8), UNCORR);
        end
        @(negedge clk);
        chk("fill_uncorr", uncorr_cnt, 8'd9);
        chk("fill_ovf", overflow, 1'b1);
        chk("fill_corr", corr_cnt, 8'd1);
        chk("fill_irq", irq, 1'b1);
        chk("stall_head", evt_addr, 16'h0000);

        // clr leaves the FIFO alone.
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        chk("clr_ovf", overflow, 1'b0);
        chk("clr_uncorr", uncorr_cnt, 8'd0);
        chk("clr_corr", corr_cnt, 8'd0);
        chk("clr_valid", evt_valid, 1'b1);

        // Full FIFO: push and pop on the same edge, then a push with no pop.
        tick();
        evt_ready = 1'b1;
        ev(3'b001, 16'h00AA, 2'b11, 1'b1, UNCORR);
        evt_ready = 1'b0;
        @(negedge clk);
        chk("fullpp_ovf", overflow, 1'b0);
        chk("fullpp_uncorr", uncorr_cnt, 8'd1);
        tick();
        ev(3'b001, 16'h00BB, 2'b00, 1'b0, UNCORR);
        @(negedge clk);
        chk("still_full_ovf", overflow, 1'b1);
        chk("still_full_uncorr", uncorr_cnt, 8'd2);
        tick();
        evt_ready = 1'b1;
        repeat (10) tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("drain1_valid", evt_valid, 1'b0);
        chk("drain1_queue", exp_q.size(), 32'd0);

        // Counter saturation with continuous draining.
        tick();
        evt_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ev(3'b010, 16'(i + 16'h0100), 2'b01, 1'b1, CORR);
        end
        repeat (4) tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("sat_corr", corr_cnt, 8'd255);
        chk("sat_uncorr", uncorr_cnt, 8'd2);
        chk("sat_queue", exp_q.size(), 32'd0);

        // clr wins over a same-cycle event, but the event is still queued.
        tick();
        clr = 1'b1;
        ev(3'b001, 16'h0F0F, 2'b10, 1'b1, UNCORR);
        clr = 1'b0;
        @(negedge clk);
        chk("clrev_corr", corr_cnt, 8'd0);
        chk("clrev_uncorr", uncorr_cnt, 8'd0);
        chk("clrev_ovf", overflow, 1'b0);
        chk("clrev_valid", evt_valid, 1'b1);
        chk("clrev_head", evt_addr, 16'h0F0F);
        tick();
        evt_ready = 1'b1;
        repeat (3) tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("drain2_queue", exp_q.size(), 32'd0);

        // Detect-only flag is uncorrectable; then reset mid-operation with an event.
        tick();
        ev(3'b100, 16'h5555, 2'b00, 1'b1, UNCORR);
        @(negedge clk);
        chk("det_type", evt_type, UNCORR);
        chk("det_uncorr", uncorr_cnt, 8'd1);
        tick();
        exp_q.delete();
        rst = 1'b1;
        rd_valid = 1'b1; flag_in = 3'b010; addr_in = 16'h7777;
        tick();
        rst = 1'b0; rd_valid = 1'b0; flag_in = 3'b000;
        @(negedge clk);
        chk("mrst_valid", evt_valid, 1'b0);
        chk("mrst_corr", corr_cnt, 8'd0);
        chk("mrst_uncorr", uncorr_cnt, 8'd0);
        chk("mrst_ovf", overflow, 1'b0);
        chk("mrst_irq", irq, 1'b0);
        chk("mrst_addr", evt_addr, 16'h0000);

`ifdef ECC_ERR_LOGGER_TIMESTAMP_EN
        // Two events five cycles apart.
        tick();
        ev(3'b010, 16'h0100, 2'b01, 1'b1, CORR);
        repeat (4) tick();
        ev(3'b010, 16'h0200, 2'b01, 1'b1, CORR);
        @(negedge clk);
        t0 = evt_tstamp;
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        @(negedge clk);
        t1 = evt_tstamp;
        chk("tstamp_delta", 32'(t1 - t0), 32'd5);
`endif

        tick();
        evt_ready = 1'b1;
        repeat (3) tick();
        evt_ready = 1'b0;
        @(negedge clk);
        chk("final_queue", exp_q.size(), 32'd0);
        chk("final_valid", evt_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
